rca_seq_ctrl: RTL and testbench
===============================

# rca_seq_ctrl

Byte-serial multi-precision adder controller. It time-multiplexes one 8-bit ripple-carry slice over `WORDS` cycles to add two `8*WORDS`-bit unsigned operands. A registered carry links the bytes. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side, and serves wide additions without instantiating a full-width adder.

## Interface
Parameters:
- `WORDS`, default 4: number of 8-bit bytes per operand; legal range 1..32; operand width `N = 8*WORDS`.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: operands `a`/`b` are valid.
- `in_ready`, output, 1: block accepts operands this cycle.
- `a`, input, N: operand A, unsigned.
- `b`, input, N: operand B, unsigned.
- `sub`, input, 1: present only with `RCA_SEQ_SUB_EN`; 1 selects A−B.
- `out_valid`, output, 1: `out` holds a completed result.
- `out_ready`, input, 1: consumer takes the result.
- `out`, output, N+1: result; `out[N]` is the final carry.
- `busy`, output, 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid&in_ready`: latch `a` and `b` into operand registers, clear the result register, set `idx=0`, set the carry register to 0 (or to `sub` when the feature is compiled in), then go to RUN.
- **RUN:**
  - Each cycle, the slice adds byte `idx` of A, byte `idx` of B (inverted if subtracting) and the carry.
  - The sum byte is written to `out[8*idx+7:8*idx]` and the slice carry-out is written back to the carry register.
  - `idx` increments each cycle.
  - When `idx==WORDS-1`, write `out[N]` with the final carry, then go to DONE.
  - `in_ready=0`. Inputs `a`/`b` are ignored after acceptance.
- **DONE:**
  - `out_valid=1`; `out` is held stable.
  - On `out_ready` go to IDLE, with `out_valid` low the next cycle.
  - `out_valid` must not drop without `out_ready`.
- No overlap: a new operand pair is accepted only in IDLE, one cycle after DONE exits.
- Arithmetic: `out = a + b` modulo 2^(N+1), exact for unsigned operands.
- `WORDS=1`: a single RUN cycle, then DONE.
- Outputs in IDLE: `out` retains the last result; `out_valid=0`.

## Timing
- Reset values: `in_ready=1` (IDLE), `out_valid=0`, `busy=0`, `out=0`, `idx=0`, carry `=0`.
- Latency: acceptance edge at cycle T gives `out_valid=1` from cycle T+WORDS through the cycle in which `out_ready` is sampled high.
- Minimum issue interval: WORDS+2 cycles when `out_ready` is held at 1.
- `rst` mid-RUN or mid-DONE: abort on the next edge, return to IDLE with reset values, and discard the partial result.
- `in_valid` asserted during RUN/DONE: not accepted; the producer must hold it.
- `out_ready` high outside DONE: ignored.

## Configuration
- `RCA_SEQ_SUB_EN` defined:
  - Adds the `sub` port, which is sampled at acceptance only.
  - `sub=1` inverts every B byte and sets the initial carry to 1, producing A−B in two's complement.
  - `out[N]=1` means no borrow (A≥B).
- Undefined:
  - No `sub` port; the initial carry is always 0.
  - Add only.

## Structure
- Package `rca_seq_pkg`:
  - `BYTE_W=8`.
  - State enum typedef `rca_seq_state_t` {IDLE, RUN, DONE}.
  - Width helper for `idx`: `$clog2(WORDS)`, minimum 1.
- Sub-module `rca8_cin`:
  - 8-bit ripple-carry slice with carry-in: a chain of 8 existing `fa` cells.
  - Purely combinational, instantiated once.
- The controller holds the FSM, `idx` counter, carry register, operand registers and result register.

## Test plan
Use `WORDS=4` unless noted.
1. `a=0xFFFFFFFF`, `b=0x00000001`, `out_ready=1` → `out_valid` rises 4 cycles after acceptance with `out=0x100000000`. `in_ready` is low for 5 cycles.
2. `a=0x12345678`, `b=0x9ABCDEF0`, `out_ready` low for 3 cycles → `out=0x0ACF13568`, held stable with `out_valid=1` until `out_ready`, then IDLE.
3. Pulse `rst` in the 2nd RUN cycle of `0xFFFFFFFF+0xFFFFFFFF` → next cycle shows IDLE, `out=0`, `out_valid=0`. A fresh `1+1` then gives `out=0x2`.
4. Two back-to-back requests with `in_valid` held high (`3+4`, then `0x80000000+0x80000000`) → results `0x7` and `0x100000000`. The second is accepted exactly one cycle after the first handshake out.
5. `WORDS=1`, `a=0xFF`, `b=0xFF` → `out=0x1FE`, 1 cycle after acceptance.
6. `RCA_SEQ_SUB_EN`, `sub=1`:
   - `a=0`, `b=1` → `out=0x0FFFFFFFF` (borrow, `out[32]=0`).
   - `a=5`, `b=3` → `out=0x100000002`.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package rca_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_seq_state_t;

    // A one-word operand still needs a one-bit byte counter.
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/rca_seq_ctrl_rca8.sv
// Combinational 8-bit ripple-carry slice built from a chain of fa cells.
module rca8_cin
    import rca_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout
);
    logic [BYTE_W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < BYTE_W; g++) begin : g_bit
        fa u_fa (
            .i_a  (i_a[g]),
            .i_b  (i_b[g]),
            .i_ci (w_c[g]),
            .o_s  (o_sum[g]),
            .o_co (w_c[g+1])
        );
    end

    assign o_cout = w_c[BYTE_W];
endmodule

// File: rtl/rca_seq_ctrl.sv
// Byte-serial adder controller: one 8-bit slice reused over WORDS cycles.
// Define RCA_SEQ_SUB_EN to add the sub port and A-B support.
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*WORDS-1:0] a,
    input  logic [BYTE_W*WORDS-1:0] b,
`ifdef RCA_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*WORDS:0]   out,
    output logic                    busy
);
    localparam int N     = BYTE_W * WORDS;
    localparam int IDX_W = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    rca_seq_state_t    r_state, w_next;
    logic [IDX_W-1:0]  r_idx;
    logic              r_cy;
    logic [N-1:0]      r_a, r_b;
    logic [N:0]        r_res;
    logic              w_accept;
    logic [BYTE_W-1:0] w_b_byte, w_sum;
    logic              w_co;

`ifdef RCA_SEQ_SUB_EN
    logic r_sub;
    assign w_b_byte = r_b[BYTE_W-1:0] ^ {BYTE_W{r_sub}};
`else
    assign w_b_byte = r_b[BYTE_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == LAST) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    rca8_cin u_slice (
        .i_a    (r_a[BYTE_W-1:0]),
        .i_b    (w_b_byte),
        .i_cin  (r_cy),
        .o_sum  (w_sum),
        .o_cout (w_co)
    );

    // Operands shift down a byte per RUN cycle so the slice always sees byte 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_cy  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
`ifdef RCA_SEQ_SUB_EN
            r_sub <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_res <= '0;
                        r_idx <= '0;
`ifdef RCA_SEQ_SUB_EN
                        r_sub <= sub;
                        r_cy  <= sub;
`else
                        r_cy  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    r_a  <= r_a >> BYTE_W;
                    r_b  <= r_b >> BYTE_W;
                    r_cy <= w_co;
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_idx == IDX_W'(k)) r_res[BYTE_W*k +: BYTE_W] <= w_sum;
                    end
                    if (r_idx == LAST) begin
                        r_res[N] <= w_co;
                        r_idx    <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = r_res;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl at WORDS=4 and WORDS=1.
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, sub_i;
    logic [31:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [32:0] out;

    logic        iv1, or1, sub1;
    logic [7:0]  a1, b1;
    logic        ir1, ov1, busy1;
    logic [8:0]  out1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef RCA_SEQ_SUB_EN
        .sub(sub_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
    );

    rca_seq_ctrl #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1),
`ifdef RCA_SEQ_SUB_EN
        .sub(sub1),
`endif
        .out_valid(ov1), .out_ready(or1), .out(out1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) at negedges until out_valid; leaves us on that negedge.
    task automatic wait_ov(input string tag);
        bit ok = 1'b0;
        for (int j = 0; j < 40 && !ok; j++) begin
            if (out_valid) ok = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_timeout"}, 64'(ok), 64'd1);
    endtask

    // Full transaction with out_ready=1; returns on a negedge in IDLE.
    task automatic do_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic s, input logic [32:0] exp);
        @(negedge clk);
        a = xa; b = xb; sub_i = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(tag);
        chk(tag, 64'(out), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        int lo, seen;
        logic [32:0] res;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub_i = 1'b0;
        a = '0; b = '0;
        iv1 = 1'b0; or1 = 1'b1; sub1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_out1", 64'(out1), 64'd0);
        rst = 1'b0;

        // 1: carry ripples through all bytes; out_ready high early is ignored
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lo = 0; seen = -1; res = '0;
        for (int j = 0; j < 8; j++) begin
            if (!in_ready) lo++;
            if (out_valid && seen < 0) begin seen = j; res = out; end
            if (j < 7) @(negedge clk);
        end
        chk("t1_latency", 64'(seen), 64'd4);
        chk("t1_out", 64'(res), 64'h1_0000_0000);
        chk("t1_inready_low", 64'(lo), 64'd5);

        // 2: backpressure holds the result
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        wait_ov("t2");
        chk("t2_out", 64'(out), 64'h0_ACF1_3568);
        repeat (3) begin
            @(negedge clk);
            chk("t2_hold_valid", 64'(out_valid), 64'd1);
            chk("t2_hold_out", 64'(out), 64'h0_ACF1_3568);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_idle_valid", 64'(out_valid), 64'd0);
        chk("t2_idle_ready", 64'(in_ready), 64'd1);
        chk("t2_idle_out", 64'(out), 64'h0_ACF1_3568);

        // 3: reset during RUN discards the partial result
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t3_in_ready", 64'(in_ready), 64'd1);
        chk("t3_out", 64'(out), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd0);
        chk("t3_busy_after", 64'(busy), 64'd0);
        do_op("t3_fresh", 32'd1, 32'd1, 1'b0, 33'h2);

        // 4: back-to-back with in_valid held high
        @(negedge clk);
        a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h8000_0000; b = 32'h8000_0000;
        chk("t4_held_off", 64'(in_ready), 64'd0);
        wait_ov("t4a");
        chk("t4a_out", 64'(out), 64'h7);
        @(negedge clk);
        chk("t4_gap_ready", 64'(in_ready), 64'd1);
        chk("t4_gap_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_second_acc", 64'(busy), 64'd1);
        wait_ov("t4b");
        chk("t4b_out", 64'(out), 64'h1_0000_0000);
        @(negedge clk);

        // 5: single-byte instance
        @(negedge clk);
        a1 = 8'hFF; b1 = 8'hFF; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        chk("t5_run_valid", 64'(ov1), 64'd0);
        chk("t5_run_busy", 64'(busy1), 64'd1);
        @(negedge clk);
        chk("t5_done_valid", 64'(ov1), 64'd1);
        chk("t5_out", 64'(out1), 64'h1FE);
        @(negedge clk);
        chk("t5_idle", 64'(ir1), 64'd1);

`ifdef RCA_SEQ_SUB_EN
        // 6: subtraction
        do_op("t6_borrow", 32'd0, 32'd1, 1'b1, 33'h0_FFFF_FFFF);
        do_op("t6_noborrow", 32'd5, 32'd3, 1'b1, 33'h1_0000_0002);
        do_op("t6_add", 32'd5, 32'd3, 1'b0, 33'h8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
